// File: rtl/fixed_point_div_arbiter.sv
// fixed_point_div_arbiter
// Shares one multi-cycle fixed-point divider among NUM_REQ requesters, one
// operation at a time. A round-robin pointer chooses the next requester. Its
// operands are latched and issued to the divider, and the arbiter waits for
// the divider's done. The quotient and an error code then return to that
// requester with a one-cycle one-hot pulse.
//
// Optional feature macro: DIV_ARB_TIMEOUT_EN
//   When defined, a watchdog ends the WAIT state after TIMEOUT_CYCLES cycles
//   without div_done_in. The response then carries q=0 and err=11.
//   When undefined, WAIT holds until done arrives, and err is never 11.
//
// Ports
//   clk_in, rst_in          clock, synchronous active-high reset
//   req_valid_in/ready_out  per-requester handshake (transfer on valid&ready)
//   req_a_in/req_b_in       packed dividends/divisors, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid_out           one-hot response pulse to the owning requester
//   rsp_q_out/rsp_err_out   shared quotient and error code (00 ok, 01 zerodiv,
//                           10 overflow, 11 timeout), held until the next response
//   div_valid_out/a/b       issue side towards the divider
//   div_busy_in..div_q_in   status and result from the divider
module fixed_point_div_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [NUM_REQ-1:0]         req_valid_in,
  output logic [NUM_REQ-1:0]         req_ready_out,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a_in,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b_in,
  output logic [NUM_REQ-1:0]         rsp_valid_out,
  output logic [WIDTH-1:0]           rsp_q_out,
  output logic [1:0]                 rsp_err_out,
  output logic                       div_valid_out,
  output logic [WIDTH-1:0]           div_a_out,
  output logic [WIDTH-1:0]           div_b_out,
  input  logic                       div_busy_in,
  input  logic                       div_done_in,
  input  logic                       div_valid_in,
  input  logic                       div_zerodiv_in,
  input  logic                       div_overflow_in,
  input  logic [WIDTH-1:0]           div_q_in
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SUMW = IDXW + 1;

  if (NUM_REQ < 2 || WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_paramCheck
    $error("fixed_point_div_arbiter: NUM_REQ must be >= 2, WIDTH and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [IDXW-1:0]    r_ptr;
  logic [IDXW-1:0]    r_tag;
  logic [WIDTH-1:0]   r_divA;
  logic [WIDTH-1:0]   r_divB;
  logic [WIDTH-1:0]   r_rspQ;
  logic [1:0]         r_rspErr;

  logic [IDXW-1:0]    w_grant;
  logic               w_grantFound;
  logic [SUMW-1:0]    w_sum;
  logic [IDXW-1:0]    w_slot;
  logic [NUM_REQ-1:0] w_grantOneHot;
  logic [NUM_REQ-1:0] w_tagOneHot;
  logic [WIDTH-1:0]   w_selA;
  logic [WIDTH-1:0]   w_selB;
  logic               w_accept;
  logic               w_done;
  logic               w_timeout;

  // Round-robin search. Slots are visited from the farthest offset back to
  // the pointer itself, so the last match written is the nearest requester
  // at or after the pointer (wrapping past NUM_REQ-1 to 0).
  always_comb begin
    w_grant      = '0;
    w_grantFound = 1'b0;
    w_sum        = '0;
    w_slot       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + SUMW'(k);
      if (w_sum >= SUMW'(NUM_REQ)) begin
        w_sum = w_sum - SUMW'(NUM_REQ);
      end
      w_slot = w_sum[IDXW-1:0];
      if (req_valid_in[w_slot]) begin
        w_grant      = w_slot;
        w_grantFound = 1'b1;
      end
    end
  end

  // Decode the winning index into a one-hot grant and select its operands.
  // Also decode the latched tag, which drives the response pulse.
  always_comb begin
    w_selA        = '0;
    w_selB        = '0;
    w_grantOneHot = '0;
    w_tagOneHot   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant == IDXW'(i)) begin
        w_selA           = req_a_in[i*WIDTH +: WIDTH];
        w_selB           = req_b_in[i*WIDTH +: WIDTH];
        w_grantOneHot[i] = 1'b1;
      end
      if (r_tag == IDXW'(i)) begin
        w_tagOneHot[i] = 1'b1;
      end
    end
  end

`ifdef DIV_ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNTW-1:0] r_waitCnt;

  // The watchdog is held at zero while issuing, so it starts from zero on
  // the first WAIT cycle. It then counts every WAIT cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_waitCnt <= '0;
    end else if (r_state == ST_ISSUE) begin
      r_waitCnt <= '0;
    end else if (r_state == ST_WAIT) begin
      r_waitCnt <= r_waitCnt + 1'b1;
    end
  end
`endif

  // State register. The divider shares this reset, so any operation still
  // in flight is simply dropped.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and the handshake strobes. Ready is combinational, so
  // a requester that drops valid before it is granted is simply skipped.
  // The issue strobe is gated by busy, so the divider sees exactly one valid.
  always_comb begin
    w_nextState   = r_state;
    req_ready_out = '0;
    rsp_valid_out = '0;
    div_valid_out = 1'b0;
    w_accept      = 1'b0;
    w_done        = 1'b0;
    w_timeout     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grantFound) begin
          req_ready_out = w_grantOneHot;
          w_accept      = 1'b1;
          w_nextState   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!div_busy_in) begin
          div_valid_out = 1'b1;
          w_nextState   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (div_done_in) begin
          w_done      = 1'b1;
          w_nextState = ST_RESP;
        end
`ifdef DIV_ARB_TIMEOUT_EN
        else if (r_waitCnt == CNTW'(TIMEOUT_CYCLES - 1)) begin
          w_timeout   = 1'b1;
          w_nextState = ST_RESP;
        end
`endif
      end
      ST_RESP: begin
        rsp_valid_out = w_tagOneHot;
        w_nextState   = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Datapath registers. Operands are sampled only in the accept cycle. They
  // stay on the divider port through ISSUE and WAIT and are zeroed afterwards.
  // A quotient from a divider result that is not valid is forced to zero. With
  // no error flag, an invalid result is reported as overflow. The pointer
  // moves past the requester that was just served.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_ptr    <= '0;
      r_tag    <= '0;
      r_divA   <= '0;
      r_divB   <= '0;
      r_rspQ   <= '0;
      r_rspErr <= 2'b00;
    end else begin
      if (w_accept) begin
        r_tag  <= w_grant;
        r_divA <= w_selA;
        r_divB <= w_selB;
      end
      if (w_done) begin
        r_rspQ   <= div_valid_in ? div_q_in : '0;
        r_rspErr <= div_zerodiv_in  ? 2'b01 :
                    div_overflow_in ? 2'b10 :
                    div_valid_in    ? 2'b00 : 2'b10;
      end
      if (w_timeout) begin
        r_rspQ   <= '0;
        r_rspErr <= 2'b11;
      end
      if (w_done || w_timeout) begin
        r_divA <= '0;
        r_divB <= '0;
      end
      if (r_state == ST_RESP) begin
        r_ptr <= (r_tag == IDXW'(NUM_REQ - 1)) ? '0 : r_tag + 1'b1;
      end
    end
  end

  assign div_a_out   = r_divA;
  assign div_b_out   = r_divB;
  assign rsp_q_out   = r_rspQ;
  assign rsp_err_out = r_rspErr;

endmodule

// File: tb/tb_fixed_point_div_arbiter.sv
// Testbench for fixed_point_div_arbiter (NUM_REQ=4, WIDTH=16, Q2.14 divider).
// A behavioural divider stub answers issued operations after a programmable
// latency. The stub can also be forced busy or told never to finish. A small
// round-robin and division model predicts every grant and response.
module tb_fixed_point_div_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int TMO  = 64;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] reqValid;
  logic [NREQ-1:0] reqReady;
  logic [W-1:0]    tbA [NREQ];
  logic [W-1:0]    tbB [NREQ];
  logic [NREQ*W-1:0] reqA;
  logic [NREQ*W-1:0] reqB;
  logic [NREQ-1:0] rspValid;
  logic [W-1:0]    rspQ;
  logic [1:0]      rspErr;
  logic            divValid;
  logic [W-1:0]    divA;
  logic [W-1:0]    divB;
  logic            divBusy;
  logic            divDone;
  logic            divValidIn;
  logic            divZd;
  logic            divOvf;
  logic [W-1:0]    divQ;

  logic            tbForceBusy;
  logic            stubNeverDone;
  int              stubLatency;
  logic            stubActive;
  int              stubCnt;
  int              stubPulses;
  logic [W-1:0]    stubQ;
  logic [1:0]      stubErr;

  int              checkCount;
  int              errorCount;
  int              refPtr;
  logic [W-1:0]    lastA;
  logic [W-1:0]    lastB;
  int              pulsesBefore;
  logic [31:0]     obsLog;
  int              n;
  int              bad;
  int              drift;
  int              seen;
  int              holdCycles;
  logic [NREQ-1:0] rndMask;

  assign reqA = {tbA[3], tbA[2], tbA[1], tbA[0]};
  assign reqB = {tbB[3], tbB[2], tbB[1], tbB[0]};
  assign divBusy = tbForceBusy | stubActive;

  fixed_point_div_arbiter #(
    .NUM_REQ(NREQ),
    .WIDTH(W),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .req_valid_in(reqValid),
    .req_ready_out(reqReady),
    .req_a_in(reqA),
    .req_b_in(reqB),
    .rsp_valid_out(rspValid),
    .rsp_q_out(rspQ),
    .rsp_err_out(rspErr),
    .div_valid_out(divValid),
    .div_a_out(divA),
    .div_b_out(divB),
    .div_busy_in(divBusy),
    .div_done_in(divDone),
    .div_valid_in(divValidIn),
    .div_zerodiv_in(divZd),
    .div_overflow_in(divOvf),
    .div_q_in(divQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Q2.14 signed division with truncation. Quotients whose magnitude does not
  // fit in 15 bits are treated as overflow.
  function automatic logic [1:0] refErr(input logic [W-1:0] a, input logic [W-1:0] b);
    int num, den, quot;
    num = int'($signed(a)) * 16384;
    den = int'($signed(b));
    if (den == 0) return 2'b01;
    quot = num / den;
    if (quot > 32767 || quot < -32767) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [W-1:0] refQ(input logic [W-1:0] a, input logic [W-1:0] b);
    int num, den, quot;
    num = int'($signed(a)) * 16384;
    den = int'($signed(b));
    if (den == 0) return '0;
    quot = num / den;
    if (quot > 32767 || quot < -32767) return '0;
    return quot[W-1:0];
  endfunction

  function automatic int refGrant(input logic [NREQ-1:0] pend, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (pend[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return 0;
  endfunction

  // Divider stub. It captures an operation on valid while not busy and
  // reports done after stubLatency cycles. On an invalid result it drives a
  // junk quotient, which the arbiter must mask to zero.
  always @(posedge clk) begin
    if (divValid) stubPulses <= stubPulses + 1;
    if (rst) begin
      stubActive <= 1'b0;
      divDone    <= 1'b0;
      divValidIn <= 1'b0;
      divZd      <= 1'b0;
      divOvf     <= 1'b0;
      divQ       <= '0;
    end else begin
      divDone    <= 1'b0;
      divValidIn <= 1'b0;
      divZd      <= 1'b0;
      divOvf     <= 1'b0;
      if (stubActive) begin
        if (stubCnt > 1) begin
          stubCnt <= stubCnt - 1;
        end else if (!stubNeverDone) begin
          stubActive <= 1'b0;
          divDone    <= 1'b1;
          divValidIn <= (stubErr == 2'b00);
          divZd      <= (stubErr == 2'b01);
          divOvf     <= (stubErr == 2'b10);
          divQ       <= (stubErr == 2'b00) ? stubQ : W'($urandom);
        end
      end else if (divValid && !divBusy) begin
        stubActive <= 1'b1;
        stubCnt    <= stubLatency;
        stubQ      <= refQ(divA, divB);
        stubErr    <= refErr(divA, divB);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ready"},    32'(reqReady), 32'h0);
    checkOutput({tag, "_rspValid"}, 32'(rspValid), 32'h0);
    checkOutput({tag, "_rspQ"},     32'(rspQ),     32'h0);
    checkOutput({tag, "_rspErr"},   32'(rspErr),   32'h0);
    checkOutput({tag, "_divValid"}, 32'(divValid), 32'h0);
    checkOutput({tag, "_divA"},     32'(divA),     32'h0);
    checkOutput({tag, "_divB"},     32'(divB),     32'h0);
  endtask

  // Called at a negedge while requester g is pending. The task waits for its
  // grant and lets the transfer happen. It then scrambles g's operands, which
  // must not reach the divider, and checks the single issue strobe.
  task automatic acceptOne(input int g, input int busyCycles);
    int cnt;
    lastA        = tbA[g];
    lastB        = tbB[g];
    pulsesBefore = stubPulses;
    cnt = 0;
    while (reqReady == '0 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("grantReady", 32'(reqReady), 32'(4'b0001 << g));
    @(posedge clk);
    #1;
    reqValid[g] = 1'b0;
    tbA[g]      = W'($urandom);
    tbB[g]      = W'($urandom);
    if (busyCycles > 0) tbForceBusy = 1'b1;
    for (int k = 0; k < busyCycles; k++) begin
      @(negedge clk);
      checkOutput("issueHeldWhileBusy", 32'(divValid), 32'h0);
      @(posedge clk);
      #1;
    end
    tbForceBusy = 1'b0;
    @(negedge clk);
    checkOutput("issueValid", 32'(divValid), 32'h1);
    checkOutput("issueA",     32'(divA),     32'(lastA));
    checkOutput("issueB",     32'(divB),     32'(lastB));
  endtask

  task automatic finishOne(input int g);
    int cnt;
    cnt = 0;
    @(negedge clk);
    while (rspValid == '0 && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    obsLog = {obsLog[27:0], rspValid};
    checkOutput("rspValid",   32'(rspValid), 32'(4'b0001 << g));
    checkOutput("rspQ",       32'(rspQ),     32'(refQ(lastA, lastB)));
    checkOutput("rspErr",     32'(rspErr),   32'(refErr(lastA, lastB)));
    checkOutput("issuePulses", 32'(stubPulses - pulsesBefore), 32'h1);
    @(negedge clk);
    checkOutput("rspPulseOneCycle", 32'(rspValid), 32'h0);
    checkOutput("rspQHeld",         32'(rspQ),     32'(refQ(lastA, lastB)));
    refPtr = (g + 1) % NREQ;
  endtask

  // Raise the requesters in mask together and serve them to completion. The
  // model predicts each grant from the round-robin pointer. Only the first
  // grant sees the forced-busy divider.
  task automatic applyStimulus(input logic [NREQ-1:0] mask, input int busyCycles);
    logic [NREQ-1:0] pending;
    int g;
    int busy;
    busy = busyCycles;
    @(posedge clk);
    #1;
    reqValid = reqValid | mask;
    @(negedge clk);
    pending = mask;
    while (pending != '0) begin
      g = refGrant(pending, refPtr);
      acceptOne(g, busy);
      busy = 0;
      finishOne(g);
      pending[g] = 1'b0;
    end
  endtask

  initial begin
    checkCount    = 0;
    errorCount    = 0;
    rst           = 1'b1;
    reqValid      = '0;
    tbForceBusy   = 1'b0;
    stubNeverDone = 1'b0;
    stubLatency   = 3;
    stubPulses    = 0;
    stubCnt       = 0;
    stubQ         = '0;
    stubErr       = 2'b00;
    obsLog        = '0;
    refPtr        = 0;
    for (int i = 0; i < NREQ; i++) begin
      tbA[i] = '0;
      tbB[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkResetOutputs("reset");

    tbA[0] = 16'h2000; tbB[0] = 16'h4000;
    applyStimulus(4'b0001, 0);
    tbA[2] = 16'h4000; tbB[2] = 16'h0000;
    applyStimulus(4'b0100, 0);
    tbA[1] = 16'h8000; tbB[1] = 16'h4000;
    applyStimulus(4'b0010, 0);
    tbA[3] = 16'h1000; tbB[3] = 16'hC000;
    applyStimulus(4'b1000, 0);

    for (int i = 0; i < NREQ; i++) begin
      tbA[i] = W'(16'h0400 * (i + 1));
      tbB[i] = 16'h4000;
    end
    obsLog = '0;
    applyStimulus(4'b1111, 0);
    checkOutput("orderAllFour", obsLog, 32'h0000_1248);
    obsLog = '0;
    applyStimulus(4'b1001, 0);
    checkOutput("orderZeroThree", obsLog, 32'h0000_0018);

    tbA[1] = 16'h0800; tbB[1] = 16'h2000;
    applyStimulus(4'b0010, 5);

    for (int r = 0; r < 25; r++) begin
      stubLatency = $urandom_range(1, 6);
      rndMask     = NREQ'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
        tbA[i] = ($urandom_range(0, 1) == 0) ? W'($urandom) : W'($urandom & 32'h0FFF);
        tbB[i] = ($urandom_range(0, 7) == 0) ? 16'h0000 : W'($urandom);
      end
      applyStimulus(rndMask, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
    end

`ifdef DIV_ARB_TIMEOUT_EN
    stubNeverDone = 1'b1;
    tbA[2] = 16'h1234; tbB[2] = 16'h2000;
    @(posedge clk);
    #1;
    reqValid[2] = 1'b1;
    @(negedge clk);
    acceptOne(2, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rspValid == '0 && n < 200);
    checkOutput("timeoutWaitCycles", 32'(n),        32'(TMO + 1));
    checkOutput("timeoutRspValid",   32'(rspValid), 32'h4);
    checkOutput("timeoutRspQ",       32'(rspQ),     32'h0);
    checkOutput("timeoutRspErr",     32'(rspErr),   32'h3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    refPtr = 0;
    holdCycles = 10;
`else
    holdCycles = 100;
`endif

    stubNeverDone = 1'b1;
    tbA[1] = 16'h0400; tbB[1] = 16'h4000;
    @(posedge clk);
    #1;
    reqValid[1] = 1'b1;
    @(negedge clk);
    acceptOne(1, 0);
    bad   = 0;
    drift = 0;
    repeat (holdCycles) begin
      @(negedge clk);
      if (rspValid != '0) bad++;
      if (divA !== 16'h0400) drift++;
    end
    checkOutput("waitNoResponse", 32'(bad),   32'h0);
    checkOutput("waitOperandHeld", 32'(drift), 32'h0);

    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    refPtr = 0;
    stubNeverDone = 1'b0;
    @(negedge clk);
    checkResetOutputs("resetInWait");
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rspValid != '0) seen++;
    end
    checkOutput("droppedOpSilent", 32'(seen), 32'h0);

    tbA[1] = 16'h1000; tbB[1] = 16'h2000;
    tbA[3] = 16'hF000; tbB[3] = 16'h4000;
    obsLog = '0;
    applyStimulus(4'b1010, 0);
    checkOutput("orderAfterReset", obsLog, 32'h0000_0028);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
